// File: rtl/addsub_sched_if.sv
// Request/response bundle for addsub_sched.
//   req0_*/req1_* : two requester channels (valid/ready, op, operands a/b)
//   rsp_*         : single response channel (valid/ready, id, s, cout, ovf)
// Handshake rule for every channel: a transfer happens on a rising clock edge
// where valid and ready are both 1; the sender holds valid and payload stable
// until that edge (a requester may withdraw valid before acceptance).
// Modports: slave = the scheduler, master = clients and result consumer.
interface addsub_sched_if #(
  parameter int N = 4
);
  logic         req0_valid;
  logic         req0_ready;
  logic         req0_op;
  logic [N-1:0] req0_a;
  logic [N-1:0] req0_b;

  logic         req1_valid;
  logic         req1_ready;
  logic         req1_op;
  logic [N-1:0] req1_a;
  logic [N-1:0] req1_b;

  logic         rsp_valid;
  logic         rsp_ready;
  logic         rsp_id;
  logic [N-1:0] rsp_s;
  logic         rsp_cout;
  logic         rsp_ovf;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_s, rsp_cout, rsp_ovf
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_s, rsp_cout, rsp_ovf
  );
endinterface

// File: rtl/addsub_sched.sv
// Two-requester round-robin scheduler in front of one shared N-bit
// add/subtract datapath. One operation is in flight at a time:
//   IDLE -> (grant) -> EXEC (compute, register result) -> RESP (hold until taken)
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : addsub_sched_if.slave (two request channels, one response)
//   dbg_state  : current FSM state (0 IDLE, 1 EXEC, 2 RESP)
// req*_ready depends only on state, rr_ptr and the valids; rsp_* are driven
// from registers, so rsp_ready never reaches req*_ready combinationally.
module addsub_sched #(
  parameter int N = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  addsub_sched_if.slave       bus,
  output logic [1:0]          dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t       state;
  state_t       state_nxt;

  logic         rr_ptr;
  logic         op_q;
  logic [N-1:0] a_q;
  logic [N-1:0] b_q;
  logic         id_q;

  logic         rsp_id_q;
  logic [N-1:0] s_q;
  logic         cout_q;
  logic         ovf_q;

  logic         grant0;
  logic         grant1;

  logic [N-1:0] bx;
  logic [N:0]   sum;
  logic         ovf_c;

  // Arbitration: a lone requester wins; on contention rr_ptr picks.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == IDLE) begin
      if (bus.req0_valid && (!bus.req1_valid || !rr_ptr)) begin
        grant0 = 1'b1;
      end else if (bus.req1_valid && (!bus.req0_valid || rr_ptr)) begin
        grant1 = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant0 || grant1) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Subtract is A + ~B + 1: invert B and feed op in as the carry.
  always_comb begin
    bx    = b_q ^ {N{op_q}};
    sum   = {1'b0, a_q} + {1'b0, bx} + {{N{1'b0}}, op_q};
    ovf_c = (a_q[N-1] == bx[N-1]) && (sum[N-1] != a_q[N-1]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr   <= 1'b0;
      op_q     <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      id_q     <= 1'b0;
      rsp_id_q <= 1'b0;
      s_q      <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      if (grant0 || grant1) begin
        op_q   <= grant1 ? bus.req1_op : bus.req0_op;
        a_q    <= grant1 ? bus.req1_a  : bus.req0_a;
        b_q    <= grant1 ? bus.req1_b  : bus.req0_b;
        id_q   <= grant1;
        // Next contention goes to the requester that did not just win.
        rr_ptr <= ~grant1;
      end
      if (state == EXEC) begin
        rsp_id_q <= id_q;
        s_q      <= sum[N-1:0];
        cout_q   <= sum[N];
        ovf_q    <= ovf_c;
      end
    end
  end

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;
  assign bus.rsp_valid  = (state == RESP);
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_s      = s_q;
  assign bus.rsp_cout   = cout_q;
  assign bus.rsp_ovf    = ovf_q;
  assign dbg_state      = state;

endmodule

// File: tb/tb_addsub_sched.sv
// Bench for addsub_sched: directed arithmetic corners, round-robin under
// contention, response backpressure, reset in EXEC/RESP, then random traffic.
// Expected results come from plain integer arithmetic on the operands.
module tb_addsub_sched;
  localparam int N = 4;
  localparam int W = N + 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  addsub_sched_if #(.N(N)) bus ();
  logic [1:0] dbg_state;

  addsub_sched #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int           n_vec = 0;
  int           n_err = 0;
  int           cyc = 0;
  bit           model_idle = 1'b1;
  bit           pref = 1'b0;       // preferred requester on contention
  int           acc_cyc = 0;
  bit [1:0]     acc_flag = 2'b00;
  bit           have_prev = 1'b0;
  logic [W-1:0] prev_rsp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: integer add/subtract, then derive flags from value ranges.
  function automatic logic [W-1:0] model_rsp(input bit id, input bit op,
                                             input logic [N-1:0] a, input logic [N-1:0] b);
    int m, half, ai, bi, sa, sb, raw, r;
    bit co, ov;
    logic [N-1:0] s;
    m    = 1 << N;
    half = m / 2;
    ai   = int'(a);
    bi   = int'(b);
    sa   = (ai >= half) ? ai - m : ai;
    sb   = (bi >= half) ? bi - m : bi;
    if (op) begin
      raw = ai - bi;
      co  = (ai >= bi);
      r   = sa - sb;
    end else begin
      raw = ai + bi;
      co  = (raw >= m);
      r   = sa + sb;
    end
    s  = N'((raw + m) % m);
    ov = (r > half - 1) || (r < -half);
    return {id, s, co, ov};
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic e0, e1, ev;
    logic [W-1:0] cur;
    cyc++;
    if (rst_n) begin
      e0 = model_idle && bus.req0_valid && (!bus.req1_valid || !pref);
      e1 = model_idle && bus.req1_valid && (!bus.req0_valid || pref);
      check("req_ready", 32'({bus.req1_ready, bus.req0_ready}), 32'({e1, e0}));
      ev = !model_idle && (cyc >= acc_cyc + 2);
      check("rsp_valid", 32'(bus.rsp_valid), 32'(ev));
      cur = {bus.rsp_id, bus.rsp_s, bus.rsp_cout, bus.rsp_ovf};
      if (bus.rsp_valid) begin
        if (have_prev) check("rsp_hold", 32'(cur), 32'(prev_rsp));
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL rsp_unexpected: got %h expected no response (cycle %0d)", cur, cyc);
        end else begin
          check("rsp", 32'(cur), 32'(exp_q[0]));
        end
        if (bus.rsp_ready) begin
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          model_idle = 1'b1;
          have_prev  = 1'b0;
        end else begin
          have_prev = 1'b1;
          prev_rsp  = cur;
        end
      end else begin
        have_prev = 1'b0;
      end
      if (e0 || e1) begin
        if (e1) exp_q.push_back(model_rsp(1'b1, bus.req1_op, bus.req1_a, bus.req1_b));
        else    exp_q.push_back(model_rsp(1'b0, bus.req0_op, bus.req0_a, bus.req0_b));
        model_idle   = 1'b0;
        pref         = e0;
        acc_cyc      = cyc;
        acc_flag[e1] = 1'b1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_req(input bit id, input bit v, input bit op,
                         input logic [N-1:0] a, input logic [N-1:0] b);
    if (id) begin
      bus.req1_valid = v; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
    end else begin
      bus.req0_valid = v; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
    end
  endtask

  task automatic set_rand_req(input bit id);
    set_req(id, 1'b1, 1'($urandom_range(0, 1)),
            N'($urandom_range(0, (1 << N) - 1)), N'($urandom_range(0, (1 << N) - 1)));
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    set_req(1'b0, 1'b0, 1'b0, '0, '0);
    set_req(1'b1, 1'b0, 1'b0, '0, '0);
    exp_q.delete();
    model_idle = 1'b1;
    pref       = 1'b0;
    acc_flag   = 2'b00;
    have_prev  = 1'b0;
    #1;
    check("reset_outputs",
          32'({bus.req1_ready, bus.req0_ready, bus.rsp_valid, bus.rsp_id,
               bus.rsp_s, bus.rsp_cout, bus.rsp_ovf, dbg_state}), 32'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_accept(input bit id);
    bit ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (acc_flag[id]) begin
        acc_flag[id] = 1'b0;
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_vec++; n_err++;
      $display("FAIL accept_timeout: requester %0d got no ready, expected accept", id);
    end
  endtask

  task automatic drain();
    bit ok = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      if (model_idle && exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_vec++; n_err++;
      $display("FAIL drain_timeout: %0d responses outstanding, expected 0", exp_q.size());
    end
  endtask

  task automatic do_req(input bit id, input bit op, input int a, input int b);
    @(posedge clk); #1;
    set_req(id, 1'b1, op, N'(a), N'(b));
    wait_accept(id);
    set_req(id, 1'b0, 1'b0, '0, '0);
    drain();
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    bit held [2];
    int prev_c;
    bit w;
    bit got;

    bus.rsp_ready = 1'b1;
    set_req(1'b0, 1'b0, 1'b0, '0, '0);
    set_req(1'b1, 1'b0, 1'b0, '0, '0);
    apply_reset();

    // Directed arithmetic corners.
    do_req(1'b0, 1'b0, 3, 4);
    do_req(1'b1, 1'b1, 5, 3);
    do_req(1'b1, 1'b1, 3, 5);
    do_req(1'b0, 1'b0, 7, 1);
    do_req(1'b1, 1'b1, 8, 1);
    do_req(1'b0, 1'b0, 15, 1);
    do_req(1'b1, 1'b1, 0, 0);
    do_req(1'b0, 1'b1, 0, 8);

    // Contention: both valid continuously, grants alternate from 0, 3 cycles apart.
    apply_reset();
    @(posedge clk); #1;
    set_rand_req(1'b0);
    set_rand_req(1'b1);
    prev_c = 0;
    for (int k = 0; k < 12; k++) begin
      got = 1'b0;
      for (int i = 0; i < 10; i++) begin
        @(posedge clk); #1;
        if (acc_flag != 2'b00) begin
          got = 1'b1;
          break;
        end
      end
      if (!got) begin
        n_vec++; n_err++;
        $display("FAIL rr_timeout: no grant, expected grant %0d", k);
        break;
      end
      w = acc_flag[1];
      acc_flag = 2'b00;
      check("rr_order", 32'(w), 32'(k % 2));
      if (k > 0) check("issue_gap", 32'(acc_cyc - prev_c), 32'(3));
      prev_c = acc_cyc;
      set_rand_req(w);
    end
    set_req(1'b0, 1'b0, 1'b0, '0, '0);
    set_req(1'b1, 1'b0, 1'b0, '0, '0);
    drain();

    // Backpressure with a second request pending.
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    set_rand_req(1'b0);
    wait_accept(1'b0);
    set_req(1'b0, 1'b0, 1'b0, '0, '0);
    set_rand_req(1'b1);
    repeat (7) begin
      @(posedge clk); #1;
    end
    check("bp_no_accept", 32'(acc_flag[1]), 32'(0));
    bus.rsp_ready = 1'b1;
    wait_accept(1'b1);
    set_req(1'b1, 1'b0, 1'b0, '0, '0);
    drain();

    // Reset while in EXEC.
    @(posedge clk); #1;
    set_rand_req(1'b1);
    wait_accept(1'b1);
    apply_reset();
    repeat (6) @(posedge clk);
    #1;

    // Reset while in RESP (last winner was requester 0).
    bus.rsp_ready = 1'b0;
    set_rand_req(1'b0);
    wait_accept(1'b0);
    set_req(1'b0, 1'b0, 1'b0, '0, '0);
    @(posedge clk); #1;
    apply_reset();
    bus.rsp_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;

    // After reset, contention must go to requester 0.
    set_rand_req(1'b0);
    set_rand_req(1'b1);
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (acc_flag != 2'b00) begin
        got = 1'b1;
        break;
      end
    end
    check("post_reset_winner", 32'({got, acc_flag}), 32'({1'b1, 2'b01}));
    acc_flag = 2'b00;
    set_req(1'b0, 1'b0, 1'b0, '0, '0);
    set_req(1'b1, 1'b0, 1'b0, '0, '0);
    drain();

    // Random traffic: random valids (with legal withdrawals) and rsp_ready.
    held[0] = 1'b0;
    held[1] = 1'b0;
    for (int c = 0; c < 800; c++) begin
      @(posedge clk); #1;
      for (int id = 0; id < 2; id++) begin
        if (acc_flag[id]) begin
          acc_flag[id] = 1'b0;
          held[id] = 1'b0;
          set_req(1'(id), 1'b0, 1'b0, '0, '0);
        end
        if (held[id]) begin
          if ($urandom_range(0, 15) == 0) begin
            held[id] = 1'b0;
            set_req(1'(id), 1'b0, 1'b0, '0, '0);
          end
        end else if ($urandom_range(0, 2) == 0) begin
          set_rand_req(1'(id));
          held[id] = 1'b1;
        end
      end
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
    end
    set_req(1'b0, 1'b0, 1'b0, '0, '0);
    set_req(1'b1, 1'b0, 1'b0, '0, '0);
    bus.rsp_ready = 1'b1;
    drain();
    acc_flag = 2'b00;

    check("queue_empty", 32'(exp_q.size()), 32'(0));

    // ---------------- report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/addsub_sched.md
Name: addsub_sched

Overview:
- Two-requester scheduler that shares one n-bit add/subtract datapath (M=0 add, M=1 subtract, two's complement, B XOR M with M as carry-in).
- Arbitrates requests round-robin and captures the winner's operands.
- Sequences one operation through the datapath, registers the result, and returns it on a single valid/ready response channel tagged with the requester ID.
- Sits between client blocks and the shared arithmetic unit; one operation is outstanding at a time.

Parameters:
- N, 4, operand/result width in bits (N >= 2)

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst_n  input  1  asynchronous active-low reset
- req0_valid  input  1  requester 0 has an operation
- req0_ready  output  1  requester 0 operation accepted this cycle
- req0_op  input  1  requester 0 mode: 0 add, 1 subtract
- req0_a  input  N  requester 0 operand A
- req0_b  input  N  requester 0 operand B
- req1_valid, req1_ready, req1_op, req1_a, req1_b: same as requester 0, for requester 1
- rsp_valid  output  1  result available
- rsp_ready  input  1  consumer takes result
- rsp_id  output  1  requester that owns the result
- rsp_s  output  N  sum/difference, mod 2^N
- rsp_cout  output  1  carry out of MSB; for subtract, 1 means no borrow (A >= B unsigned)
- rsp_ovf  output  1  signed overflow

Behaviour:
- Reset (async assert, sync-released use): state=IDLE, rr_ptr=0.
  - All outputs 0: req*_ready, rsp_valid, rsp_id, rsp_s, rsp_cout, rsp_ovf.
  - Operand and result registers cleared to 0.
- States: IDLE, EXEC, RESP.
- IDLE:
  - Arbitration: if exactly one reqX_valid is high, that requester wins. If both are high, the requester equal to rr_ptr wins.
  - reqX_ready = 1 combinationally for the winner only, and only in IDLE. A transfer occurs when valid & ready.
  - On transfer: latch op, a, b and id; set rr_ptr = ~id; go to EXEC.
  - With no valid request: stay in IDLE; rr_ptr is unchanged.
- EXEC (one cycle):
  - Drive the latched operands through the add/sub datapath.
  - Register S, Cout and ovf into the rsp_* registers; go to RESP.
  - ovf = (A[N-1] == Bx[N-1]) & (S[N-1] != A[N-1]), where Bx = B XOR {N{op}}.
- RESP:
  - rsp_valid = 1; rsp_id, rsp_s, rsp_cout and rsp_ovf are held stable while rsp_valid=1 and rsp_ready=0.
  - When rsp_valid & rsp_ready: go to IDLE and clear rsp_valid next cycle.
  - No new request is accepted in EXEC or RESP (req*_ready = 0).
- Latency: accept at edge t -> rsp_valid high from cycle t+2. Minimum issue interval is 3 cycles with rsp_ready held at 1.
- Requester rules:
  - A requester must hold valid and operands stable until ready.
  - A dropped valid before acceptance is legal; no state change results.
- Arithmetic is modulo 2^N. Cout and ovf are independent outputs; both may be 1 in the same result.
- Reset mid-operation (EXEC or RESP): the operation is discarded, no response is issued, and state returns to IDLE with rr_ptr=0.
- rsp_* outputs are registered; req*_ready is combinational from state, rr_ptr and valids only. There is no combinational path from rsp_ready to req*_ready.

Test Plan:
- Reset, then req0 add a=3 b=4 alone -> req0_ready high in that cycle; 2 cycles later rsp_valid=1, id=0, s=7, cout=0, ovf=0.
- req1 sub a=5 b=3 -> rsp: id=1, s=2, cout=1, ovf=0. Then sub a=3 b=5 -> s=14 (0xE), cout=0, ovf=0.
- Overflow: add a=7 b=1 -> s=8, cout=0, ovf=1. Sub a=8 b=1 -> s=7, cout=1, ovf=1. Add a=15 b=1 -> s=0, cout=1, ovf=0.
- Both valid continuously, rsp_ready=1 -> grants alternate 0,1,0,1 starting with 0 after reset; each grant is 3 cycles apart; response IDs match.
- Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_* stable; both req*_ready stay 0; a pending request is accepted only after the rsp handshake completes.
- Assert rst_n low during EXEC, then during RESP -> all outputs 0 immediately; no response appears after release; the next request is served with rr_ptr=0.
